if_fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of ID.
- Owns the PC and issues in-order word requests to instruction memory over a req/gnt + rvalid handshake.
- Buffers returned instructions with their PCs in a small queue and presents them to ID with valid/ready.
- Accepts a branch/jump redirect from EX that flushes all buffered and in-flight fetches.

---
 rtl/if_fetch_unit_pkg.sv | 21 ++
 rtl/if_fetch_unit_fifo.sv | 51 +++++
 rtl/if_fetch_unit.sv | 116 +++++++++++
 tb/tb_if_fetch_unit.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared fetch-stage types and defaults.
// Imported by the fetch unit and its queue.
package if_fetch_unit_pkg;

  localparam int WIDTH = 32;

  localparam logic [WIDTH-1:0] DEF_NOP_INSTR = 32'h0000_0013;
  localparam logic [WIDTH-1:0] DEF_RESET_PC  = 32'h0000_0000;

  typedef struct packed {
    logic [WIDTH-1:0] instr;
    logic [WIDTH-1:0] pc;
  } fetch_entry_t;

  function automatic logic [WIDTH-1:0] align_word(
    input logic [WIDTH-1:0] a
  );
    return {a[WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_unit_fifo.sv
// Small synchronous FIFO used for the instruction
// queue and the in-flight pc-tag queue.
module if_fetch_unit_fifo #(
  parameter  int W     = 64,
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  a_no_overflow: assert property (
    @(posedge clk) disable iff (rst)
    !(push && full)
  );

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word
// fetches and hands buffered instructions to ID.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [WIDTH-1:0] RESET_PC  = DEF_RESET_PC,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic             i_clk,
  input  logic             i_reset,
  output logic             o_imem_req,
  output logic [WIDTH-1:0] o_imem_addr,
  input  logic             i_imem_gnt,
  input  logic             i_imem_rvalid,
  input  logic [WIDTH-1:0] i_imem_rdata,
  input  logic             i_redirect,
  input  logic [WIDTH-1:0] i_redirect_pc,
  input  logic             i_id_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_instr,
  output logic [WIDTH-1:0] o_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] pc;
  logic [CW-1:0]    outstanding;
  logic [CW-1:0]    drop;
  logic [CW-1:0]    out_next;
  logic [CW-1:0]    used;
  logic [CW-1:0]    q_count;
  logic [CW-1:0]    tag_count;
  logic [WIDTH-1:0] tag_pc;
  fetch_entry_t     q_din;
  fetch_entry_t     q_dout;
  logic req, grant, resp, discard;
  logic q_push, q_pop, q_empty, q_full;
  logic tag_full, tag_empty;

  // A slot freed by ID this cycle is reused at once,
  // giving one fetch per cycle in steady state.
  always_comb begin
    q_pop    = !q_empty && i_id_ready;
    used     = q_count + outstanding - CW'(q_pop);
    req      = !i_reset && !i_redirect
            && (used < CW'(DEPTH));
    grant    = req && i_imem_gnt;
    resp     = i_imem_rvalid && (outstanding != '0);
    discard  = (drop != '0) || i_redirect;
    q_push   = resp && !discard;
    out_next = outstanding + CW'(grant) - CW'(resp);
    q_din    = '{instr: i_imem_rdata, pc: tag_pc};
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= out_next;
      if (i_redirect) begin
        pc   <= align_word(i_redirect_pc);
        drop <= out_next;
      end else begin
        if (grant) pc <= pc + WIDTH'(4);
        if (resp && (drop != '0)) drop <= drop - 1'b1;
      end
    end
  end

  if_fetch_unit_fifo #(
    .W     ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_instr_q (
    .clk   (i_clk),
    .rst   (i_reset),
    .push  (q_push),
    .pop   (q_pop),
    .flush (i_redirect),
    .din   (q_din),
    .dout  (q_dout),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  // Tags are never flushed; dropped responses pop them.
  if_fetch_unit_fifo #(
    .W     (WIDTH),
    .DEPTH (DEPTH)
  ) u_tag_q (
    .clk   (i_clk),
    .rst   (i_reset),
    .push  (grant),
    .pop   (resp),
    .flush (1'b0),
    .din   (pc),
    .dout  (tag_pc),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_count)
  );

  logic unused_bits;
  assign unused_bits = ^{i_redirect_pc[1:0], q_full,
                         tag_full, tag_empty, tag_count};

  assign o_imem_req  = req;
  assign o_imem_addr = pc;
  assign o_valid     = !q_empty;
  assign o_instr     = q_empty ? NOP_INSTR : q_dout.instr;
  assign o_pc        = q_empty ? '0 : q_dout.pc;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with an in-order
// memory model answering one cycle after grant.
module tb_if_fetch_unit;
  import if_fetch_unit_pkg::*;

  logic        clk;
  logic        i_reset;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        i_id_ready;
  logic        o_valid;
  logic [31:0] o_instr;
  logic [31:0] o_pc;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  logic [31:0] pending[$];

  typedef struct {
    logic        rst, gnt, rdy, redir;
    logic [31:0] rpc;
    logic        en;
    logic        ereq;
    logic [31:0] eaddr;
    logic        evalid;
    logic [31:0] epc;
  } vec_t;

  vec_t tbl[$];

  if_fetch_unit #(
    .RESET_PC  (32'h0),
    .DEPTH     (2),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .i_clk         (clk),
    .i_reset       (i_reset),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_gnt    (i_imem_gnt),
    .i_imem_rvalid (i_imem_rvalid),
    .i_imem_rdata  (i_imem_rdata),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .i_id_ready    (i_id_ready),
    .o_valid       (o_valid),
    .o_instr       (o_instr),
    .o_pc          (o_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    logic [15:0] lo;
    lo = a[15:0];
    return {lo ^ 16'hC0DE, lo};
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h want %h",
               nm, cyc_n, act, exp);
    end
  endtask

  task automatic add(input logic rst, gnt, rdy, redir,
                     input logic [31:0] rpc,
                     input logic en, ereq,
                     input logic [31:0] eaddr,
                     input logic evalid,
                     input logic [31:0] epc);
    vec_t t;
    t.rst = rst; t.gnt = gnt; t.rdy = rdy;
    t.redir = redir; t.rpc = rpc; t.en = en;
    t.ereq = ereq; t.eaddr = eaddr;
    t.evalid = evalid; t.epc = epc;
    tbl.push_back(t);
  endtask

  task automatic cyc(input vec_t v);
    logic [31:0] ei;
    i_reset       = v.rst;
    i_imem_gnt    = v.gnt;
    i_id_ready    = v.rdy;
    i_redirect    = v.redir;
    i_redirect_pc = v.rpc;
    i_imem_rvalid = v.en && !v.rst && (pending.size() > 0);
    i_imem_rdata  = i_imem_rvalid ? word(pending[0]) : 32'h0;
    #4;
    ei = v.evalid ? word(v.epc) : 32'h0000_0013;
    chk("req", {31'h0, o_imem_req}, {31'h0, v.ereq});
    chk("addr", o_imem_addr, v.eaddr);
    chk("valid", {31'h0, o_valid}, {31'h0, v.evalid});
    chk("pc", o_pc, v.epc);
    chk("instr", o_instr, ei);
    if (i_imem_rvalid) void'(pending.pop_front());
    if (o_imem_req && i_imem_gnt) pending.push_back(o_imem_addr);
    if (v.rst) pending.delete();
    cyc_n++;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic rst, gnt, rdy, redir,
                     input logic [31:0] rpc,
                     input logic en, ereq,
                     input logic [31:0] eaddr,
                     input logic evalid,
                     input logic [31:0] epc);
    vec_t t;
    t.rst = rst; t.gnt = gnt; t.rdy = rdy;
    t.redir = redir; t.rpc = rpc; t.en = en;
    t.ereq = ereq; t.eaddr = eaddr;
    t.evalid = evalid; t.epc = epc;
    cyc(t);
  endtask

  initial begin
    i_reset       = 1'b1;
    i_imem_gnt    = 1'b0;
    i_imem_rvalid = 1'b0;
    i_imem_rdata  = 32'h0;
    i_redirect    = 1'b0;
    i_redirect_pc = 32'h0;
    i_id_ready    = 1'b0;

    // reset, cold start, stall of 5, release
    add(1,0,0,0,0,0, 0,32'h0,  0,32'h0);
    add(0,1,1,0,0,1, 1,32'h0,  0,32'h0);
    add(0,1,1,0,0,1, 1,32'h4,  0,32'h0);
    for (int i = 0; i < 5; i++)
      add(0,1,0,0,0,1, 0,32'h8, 1,32'h0);
    add(0,1,1,0,0,1, 1,32'h8,  1,32'h0);
    add(0,1,1,0,0,1, 1,32'hc,  1,32'h4);
    add(0,1,1,0,0,1, 1,32'h10, 1,32'h8);
    // two in flight, then redirect to 0x100
    add(0,1,1,0,0,0, 1,32'h14, 1,32'hc);
    add(0,1,1,1,32'h100,0, 0,32'h18, 0,32'h0);
    add(0,1,1,0,0,1, 0,32'h100, 0,32'h0);
    add(0,1,1,0,0,1, 1,32'h100, 0,32'h0);
    add(0,1,1,0,0,1, 1,32'h104, 0,32'h0);
    add(0,1,1,0,0,1, 1,32'h108, 1,32'h100);
    add(0,1,1,0,0,1, 1,32'h10c, 1,32'h104);
    // misaligned redirect target
    add(0,1,1,1,32'h203,1, 0,32'h110, 1,32'h108);
    add(0,1,1,0,0,1, 1,32'h200, 0,32'h0);
    add(0,1,1,0,0,1, 1,32'h204, 0,32'h0);
    add(0,1,1,0,0,1, 1,32'h208, 1,32'h200);

    @(posedge clk);
    #1;
    foreach (tbl[i]) cyc(tbl[i]);

    // redirect during stall, same cycle as rvalid
    run(0,1,0,0,0,0,       0,32'h20c, 1,32'h204);
    run(0,1,0,1,32'h300,1, 0,32'h20c, 1,32'h204);
    run(0,1,0,0,0,1,       1,32'h300, 0,32'h0);
    run(0,1,0,0,0,1,       1,32'h304, 0,32'h0);
    run(0,1,0,0,0,1,       0,32'h308, 1,32'h300);
    run(0,1,1,0,0,1,       1,32'h308, 1,32'h300);
    run(0,1,1,0,0,1,       1,32'h30c, 1,32'h304);

    // grant withheld for 3 cycles
    run(0,0,1,0,0,1, 1,32'h310, 1,32'h308);
    run(0,0,1,0,0,1, 1,32'h310, 1,32'h30c);
    run(0,0,1,0,0,1, 1,32'h310, 0,32'h0);
    run(0,1,1,0,0,1, 1,32'h310, 0,32'h0);
    run(0,1,1,0,0,1, 1,32'h314, 0,32'h0);
    run(0,1,1,0,0,1, 1,32'h318, 1,32'h310);

    // reset mid-stream, restart at RESET_PC
    run(1,1,1,0,0,1, 0,32'h31c, 1,32'h314);
    run(0,1,1,0,0,1, 1,32'h0,   0,32'h0);
    run(0,1,1,0,0,1, 1,32'h4,   0,32'h0);
    run(0,1,1,0,0,1, 1,32'h8,   1,32'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
